fhn_core: RTL and testbench
===========================

# fhn_core

FitzHugh–Nagumo neuron model core in Q3.12 signed fixed point. Each clock it advances the two state variables, membrane potential v and recovery w, by one forward-Euler step under the external stimulus current i. It is the compute element of the neuron accelerator, and both state variables are exposed for monitoring.

## Interface
Parameters:
- WIDTH, 16: width of the i, v and w words.
- FRAC, 12: fraction bits (Q3.12; 4096 = 1.0).
- A, 2867: model constant a = 0.7.
- B, 3277: model constant b = 0.8.
- EPS, 328: time-scale constant ε = 0.08.
- THIRD, 1365: 1/3 in Q12.
- DT_SHIFT, 5: Euler step dt = 2^-DT_SHIFT.
- V_INIT, -4913: reset value of v (rest potential, about -1.1994).
- W_INIT, -2557: reset value of w (rest recovery, about -0.6243).

Ports:
- clk, in, 1: the single clock; all state changes on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- i, in, WIDTH: signed stimulus current, Q3.12.
- v, out, WIDTH: signed membrane potential, Q3.12, registered.
- w_out, out, WIDTH: signed recovery variable, Q3.12, registered.

## Operation
- State is two WIDTH-bit signed registers, v and w. The outputs drive them directly; there is no output logic.
- All intermediates are at least 2·WIDTH bits signed. Every ">>>" below is an arithmetic right shift (floor), with no rounding.
- Per-step datapath, evaluated from the current register values:
  - v2 = (v·v) >>> FRAC
  - v3 = (v2·v) >>> FRAC
  - c = (v3·THIRD) >>> FRAC
  - dv = v − c − w + i
  - bw = (B·w) >>> FRAC
  - dw = (EPS·(v + A − bw)) >>> FRAC
  - v_next = v + (dv >>> DT_SHIFT)
  - w_next = w + (dw >>> DT_SHIFT)
- v_next and w_next are reduced to WIDTH bits as described in Configuration.
- The core has no enable and no handshake. It steps on every clock while rst = 0.
- (V_INIT, W_INIT) is an exact fixed point of the datapath when i = 0: dv = 0 and dw = 0.

## Timing
- Reset: on a rising edge with rst = 1, v ← V_INIT and w_out ← W_INIT, regardless of i. Reset asserted mid-spike takes effect on that edge; the state is not preserved.
- First edge with rst = 0: the state takes its first Euler step.
- Latency: i sampled at edge n affects v at edge n+1 and w_out at edge n+2 (through v). The datapath is combinational between the registers, so there is one step per cycle.
- i may change on any cycle. There are no illegal input values.

## Configuration
- FHN_SAT_EN defined: v_next and w_next saturate to [−32768, +32767] before the register load. Overflow clamps and never wraps the sign.
- FHN_SAT_EN undefined: v_next and w_next are truncated to their low WIDTH bits, i.e. two's-complement wrap. This is smaller, and acceptable when |i| ≤ 2.0.
- The datapath math is otherwise identical in both builds.

## Test plan
- Reset: assert rst for 10 cycles with i = 4098 → v = −4913, w_out = −2557 after the first edge, held constant throughout reset.
- Rest stability: release reset with i = 0 and run 2000 cycles → v = −4913 and w_out = −2557 on every cycle.
- Single step: from the reset state, apply i = 4098 → after one edge v = −4785 and w_out = −2557 (dv = 4098, dw = 0).
- Spiking: hold i = 4098 for 4000 cycles → at least 2 upward crossings of v through 0, peak v > +6144 (1.5), and w_out oscillates.
- Relaxation: after the spiking run, set i = 0 for 20000 cycles → no further zero crossings after the first 2000 cycles; final v within ±128 LSB of −4913 and w_out within ±128 LSB of −2557.
- Overdrive (FHN_SAT_EN defined): i = +32767 for 4000 cycles → v and w_out never jump between values above +24576 and below −24576 on consecutive cycles; rst mid-run returns both to the reset values on the next edge.

Source files
------------

// File: rtl/fhn_core.sv
// ---------------------------------------------------------------------------
// fhn_core
// FitzHugh-Nagumo neuron compute element, Q3.12 signed fixed point.
// On every rising clock edge the membrane potential v and the recovery
// variable w advance by one forward-Euler step (dt = 2^-DT_SHIFT) under the
// stimulus current i. There is no enable and no handshake: the core steps on
// every clock while rst is low.
//
// Ports:
//   clk    in   1      clock, all state changes on the rising edge
//   rst    in   1      synchronous active-high reset (v <- V_INIT, w <- W_INIT)
//   i      in   WIDTH  signed stimulus current, Q3.12
//   v      out  WIDTH  signed membrane potential, Q3.12, registered
//   w_out  out  WIDTH  signed recovery variable, Q3.12, registered
//
// Configuration macro:
//   FHN_SAT_EN  defined   : v_next / w_next saturate to the WIDTH-bit signed range
//               undefined : v_next / w_next wrap (low WIDTH bits kept)
// ---------------------------------------------------------------------------
module fhn_core #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 12,
  parameter int A        = 2867,
  parameter int B        = 3277,
  parameter int EPS      = 328,
  parameter int THIRD    = 1365,
  parameter int DT_SHIFT = 5,
  parameter int V_INIT   = -4913,
  parameter int W_INIT   = -2557
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] i,
  output logic signed [WIDTH-1:0] v,
  output logic signed [WIDTH-1:0] w_out
);

  // Intermediates are 3*WIDTH wide: v^2 >>> FRAC can reach ~2^(2*WIDTH-FRAC-2)
  // and the following multiply by v would overflow a 2*WIDTH word at full
  // scale (which the saturating build can reach). 3*WIDTH keeps the math exact.
  localparam int XW = 3 * WIDTH;

  localparam logic signed [XW-1:0] P_A     = XW'(A);
  localparam logic signed [XW-1:0] P_B     = XW'(B);
  localparam logic signed [XW-1:0] P_EPS   = XW'(EPS);
  localparam logic signed [XW-1:0] P_THIRD = XW'(THIRD);

  logic signed [WIDTH-1:0] r_v;
  logic signed [WIDTH-1:0] r_w;

  logic signed [XW-1:0] w_v;
  logic signed [XW-1:0] w_w;
  logic signed [XW-1:0] w_i;
  logic signed [XW-1:0] w_v2;
  logic signed [XW-1:0] w_v3;
  logic signed [XW-1:0] w_c;
  logic signed [XW-1:0] w_dv;
  logic signed [XW-1:0] w_bw;
  logic signed [XW-1:0] w_dw;
  logic signed [XW-1:0] w_v_next;
  logic signed [XW-1:0] w_w_next;
  logic signed [WIDTH-1:0] w_v_red;
  logic signed [WIDTH-1:0] w_w_red;

  // Sign-extend the state and stimulus into the wide datapath.
  assign w_v = XW'(r_v);
  assign w_w = XW'(r_w);
  assign w_i = XW'(i);

  // Cubic term v^3/3; every >>> is a flooring arithmetic shift.
  assign w_v2 = (w_v * w_v) >>> FRAC;
  assign w_v3 = (w_v2 * w_v) >>> FRAC;
  assign w_c  = (w_v3 * P_THIRD) >>> FRAC;
  assign w_dv = w_v - w_c - w_w + w_i;

  // Recovery dynamics: eps * (v + a - b*w).
  assign w_bw = (P_B * w_w) >>> FRAC;
  assign w_dw = (P_EPS * (w_v + P_A - w_bw)) >>> FRAC;

  // Euler step with dt = 2^-DT_SHIFT.
  assign w_v_next = w_v + (w_dv >>> DT_SHIFT);
  assign w_w_next = w_w + (w_dw >>> DT_SHIFT);

`ifdef FHN_SAT_EN
  localparam logic signed [XW-1:0] SAT_MAX = XW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_MIN = XW'(-(2 ** (WIDTH - 1)));

  // Clamp so that an overdriven neuron pins at the rail instead of wrapping
  // its sign, which would look like a spurious spike to downstream logic.
  always_comb begin
    w_v_red = w_v_next[WIDTH-1:0];
    if (w_v_next > SAT_MAX) begin
      w_v_red = SAT_MAX[WIDTH-1:0];
    end else if (w_v_next < SAT_MIN) begin
      w_v_red = SAT_MIN[WIDTH-1:0];
    end

    w_w_red = w_w_next[WIDTH-1:0];
    if (w_w_next > SAT_MAX) begin
      w_w_red = SAT_MAX[WIDTH-1:0];
    end else if (w_w_next < SAT_MIN) begin
      w_w_red = SAT_MIN[WIDTH-1:0];
    end
  end
`else
  // Two's-complement wrap: keep the low WIDTH bits. Fine for |i| <= 2.0,
  // where the trajectory stays well inside the representable range.
  logic w_unused_hi;
  assign w_v_red     = w_v_next[WIDTH-1:0];
  assign w_w_red     = w_w_next[WIDTH-1:0];
  assign w_unused_hi = ^{w_v_next[XW-1:WIDTH], w_w_next[XW-1:WIDTH]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= WIDTH'(V_INIT);
      r_w <= WIDTH'(W_INIT);
    end else begin
      r_v <= w_v_red;
      r_w <= w_w_red;
    end
  end

  assign v     = r_v;
  assign w_out = r_w;

endmodule

// File: tb/tb_fhn_core.sv
// ---------------------------------------------------------------------------
// tb_fhn_core
// Scoreboard bench for fhn_core. The driver applies rst/i once per cycle,
// advances a reference model of the FitzHugh-Nagumo Euler step and pushes the
// expected (v, w) after the coming edge into exp_q. An independent monitor
// samples the DUT 1 time unit after every rising edge, pops and compares, and
// gathers trajectory statistics (zero crossings, peaks, jumps) that are
// checked against the behavioural limits at the end of the run.
// ---------------------------------------------------------------------------
module tb_fhn_core;

  localparam int  W       = 16;
  localparam int  V_REST  = -4913;
  localparam int  W_REST  = -2557;
  localparam int  I_SPIKE = 4098;

  // Phase tags carried through the scoreboard with each expected value.
  localparam logic [2:0] PH_RST   = 3'd0;
  localparam logic [2:0] PH_REST  = 3'd1;
  localparam logic [2:0] PH_STEP  = 3'd2;
  localparam logic [2:0] PH_SPIKE = 3'd3;
  localparam logic [2:0] PH_RELAX = 3'd4;
  localparam logic [2:0] PH_RAND  = 3'd5;
  localparam logic [2:0] PH_OVER  = 3'd6;
  localparam logic [2:0] PH_ORST  = 3'd7;

  // clock / reset ------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [W-1:0] i_stim = '0;
  logic signed [W-1:0] v_dut;
  logic signed [W-1:0] w_dut;

  always #5 clk = ~clk;

  fhn_core dut (
    .clk   (clk),
    .rst   (rst),
    .i     (i_stim),
    .v     (v_dut),
    .w_out (w_dut)
  );

  // scoreboard ---------------------------------------------------------------
  logic [2*W+2:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  longint m_v = V_REST;
  longint m_w = W_REST;

  // FitzHugh-Nagumo in real-valued terms, quantised to Q3.12:
  //   dv/dt = v - v^3/3 - w + i,  dw/dt = eps (v + a - b w),  dt = 1/32
  function automatic longint fix_mul(input longint x, input longint y);
    return (x * y) >>> 12;
  endfunction

  function automatic longint to_word(input longint x);
`ifdef FHN_SAT_EN
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
`else
    return longint'(shortint'(x));
`endif
  endfunction

  task automatic model_step(input longint cv, input longint cw, input longint ci,
                            output longint nv, output longint nw);
    longint cube_third, dv, dw;
    cube_third = fix_mul(fix_mul(fix_mul(cv, cv), cv), 1365);
    dv = cv - cube_third - cw + ci;
    dw = fix_mul(328, cv + 2867 - fix_mul(3277, cw));
    nv = to_word(cv + (dv >>> 5));
    nw = to_word(cw + (dw >>> 5));
  endtask

  // driver -------------------------------------------------------------------
  task automatic drive(input logic r, input logic signed [W-1:0] ival,
                       input logic [2:0] ph);
    longint nv, nw;
    rst    = r;
    i_stim = ival;
    if (r) begin
      nv = V_REST;
      nw = W_REST;
    end else begin
      model_step(m_v, m_w, longint'(ival), nv, nw);
    end
    m_v = nv;
    m_w = nw;
    exp_q.push_back({ph, W'(nv), W'(nw)});
    @(negedge clk);
  endtask

  function automatic string ph_name(input logic [2:0] ph);
    case (ph)
      PH_RST:   return "reset";
      PH_REST:  return "rest";
      PH_STEP:  return "single_step";
      PH_SPIKE: return "spiking";
      PH_RELAX: return "relaxation";
      PH_RAND:  return "random";
      PH_OVER:  return "overdrive";
      default:  return "overdrive_reset";
    endcase
  endfunction

  // monitor statistics -------------------------------------------------------
  int sp_up      = 0;
  int sp_peak    = -32768;
  int sp_wmin    = 32767;
  int sp_wmax    = -32768;
  int rl_cnt     = 0;
  int rl_late_x  = 0;
  int rl_last_v  = 0;
  int rl_last_w  = 0;
  int od_jumps   = 0;
  logic signed [W-1:0] prev_v = '0;
  logic signed [W-1:0] prev_w = '0;
  logic [2:0]          prev_ph = PH_RST;

  function automatic bit big_jump(input int a, input int b);
    return (a > 24576 && b < -24576) || (a < -24576 && b > 24576);
  endfunction

  initial begin
    logic [2*W+2:0]      e;
    logic [2:0]          ph;
    logic signed [W-1:0] ev, ew;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        ph = e[2*W+2:2*W];
        ev = e[2*W-1:W];
        ew = e[W-1:0];
        n_checks++;
        if (v_dut === ev && w_dut === ew) begin
          n_pass++;
        end else begin
          $display("FAIL %s @%0t: got v=%0d w_out=%0d, expected v=%0d w_out=%0d",
                   ph_name(ph), $time, v_dut, w_dut, ev, ew);
        end

        if (ph == PH_SPIKE) begin
          if (prev_ph == PH_SPIKE && prev_v < 0 && v_dut >= 0) sp_up++;
          if (int'(v_dut) > sp_peak) sp_peak = int'(v_dut);
          if (int'(w_dut) < sp_wmin) sp_wmin = int'(w_dut);
          if (int'(w_dut) > sp_wmax) sp_wmax = int'(w_dut);
        end
        if (ph == PH_RELAX) begin
          rl_cnt++;
          if (rl_cnt > 2000 && ((prev_v < 0) != (v_dut < 0))) rl_late_x++;
          rl_last_v = int'(v_dut);
          rl_last_w = int'(w_dut);
        end
        if (ph == PH_OVER && prev_ph == PH_OVER) begin
          if (big_jump(int'(prev_v), int'(v_dut)) || big_jump(int'(prev_w), int'(w_dut)))
            od_jumps++;
        end
        prev_v  = v_dut;
        prev_w  = w_dut;
        prev_ph = ph;
      end
    end
  end

  task automatic check(input bit ok, input string name, input int got, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, got, req);
  endtask

  // watchdog -----------------------------------------------------------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d entries pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  // stimulus -----------------------------------------------------------------
  initial begin
    int r_i;
    int k;

    // reset held with a non-zero stimulus
    for (int n = 0; n < 10; n++) drive(1'b1, W'(I_SPIKE), PH_RST);
    // rest stability
    for (int n = 0; n < 2000; n++) drive(1'b0, '0, PH_REST);
    // first step under stimulus
    drive(1'b0, W'(I_SPIKE), PH_STEP);
    // spiking
    for (int n = 0; n < 4000; n++) drive(1'b0, W'(I_SPIKE), PH_SPIKE);
    // relaxation back to rest
    for (int n = 0; n < 20000; n++) drive(1'b0, '0, PH_RELAX);
    // random stimulus within |i| <= 2.0 with occasional resets
    for (int n = 0; n < 3000; n++) begin
      r_i = int'($urandom_range(16384, 0)) - 8192;
      drive(($urandom_range(199, 0) == 0), W'(r_i), PH_RAND);
    end
    // overdrive with a reset in the middle
    drive(1'b1, '0, PH_ORST);
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) drive(1'b1, 16'sd32767, PH_ORST);
      else           drive(1'b0, 16'sd32767, PH_OVER);
    end

    // drain the scoreboard, bounded
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(exp_q.size() == 0, "scoreboard_drain", exp_q.size(), 0);

    check(sp_up >= 2, "spike_up_crossings", sp_up, 2);
    check(sp_peak > 6144, "spike_peak_v", sp_peak, 6145);
    check((sp_wmax - sp_wmin) > 1024, "spike_w_swing", sp_wmax - sp_wmin, 1025);
    check(rl_late_x == 0, "relax_late_crossings", rl_late_x, 0);
    check(rl_last_v >= V_REST - 128 && rl_last_v <= V_REST + 128,
          "relax_final_v", rl_last_v, V_REST);
    check(rl_last_w >= W_REST - 128 && rl_last_w <= W_REST + 128,
          "relax_final_w", rl_last_w, W_REST);
`ifdef FHN_SAT_EN
    check(od_jumps == 0, "overdrive_no_wrap", od_jumps, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
